// File: rtl/fib_pkg.sv
// Shared definitions for the binary-to-Zeckendorf converter.
//   IN_W_DEF / OUT_W_DEF : default widths, shared with stream_encryption
//   fib_state_e          : converter FSM states
//   zeck_ref()           : reference greedy Zeckendorf encoder (checking only)
package fib_pkg;

  localparam int unsigned IN_W_DEF  = 16;
  localparam int unsigned OUT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    GROW,
    DESCEND
  } fib_state_e;

  // Bit k of the result carries weight F(k+2): 1, 2, 3, 5, 8, ...
  function automatic logic [OUT_W_DEF-1:0] zeck_ref(input logic [IN_W_DEF-1:0] value);
    logic [OUT_W_DEF-1:0] code;
    longint unsigned      w [OUT_W_DEF];
    longint unsigned      rem;
    code = '0;
    rem  = longint'(value);
    w[0] = 1;
    w[1] = 2;
    for (int k = 2; k < int'(OUT_W_DEF); k++) begin
      w[k] = w[k-1] + w[k-2];
    end
    for (int k = int'(OUT_W_DEF) - 1; k >= 0; k--) begin
      if (w[k] <= rem) begin
        code[k] = 1'b1;
        rem     = rem - w[k];
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/bin_to_fibonacci.sv
// Converts an unsigned binary value into its Zeckendorf (Fibonacci standard-form) code word.
// Fibonacci terms are generated on the fly: GROW walks the term pair (a, b) up past the
// value, DESCEND walks back down greedily subtracting terms and setting code bits.
//
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   en_b_f       : start request, only honoured in IDLE
//   bin_in       : value to convert, captured on the accepting edge
//   fib_out      : code word, bit k weighs F(k+2); held until the next conversion completes
//   convert_done : one-cycle pulse when fib_out has just been updated
//   busy         : high from the accepting edge until the completing edge
module bin_to_fibonacci
  import fib_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned FW    = IN_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_b_f,
  input  logic [IN_W-1:0]  bin_in,
  output logic [OUT_W-1:0] fib_out,
  output logic             convert_done,
  output logic             busy
);

  localparam int unsigned     IDX_W   = $clog2(OUT_W);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(OUT_W - 1);

  fib_state_e       state_q, state_d;
  logic [FW-1:0]    res_q, res_d;
  logic [FW-1:0]    a_q, a_d;
  logic [FW-1:0]    b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] shadow_q, shadow_d;
  logic [OUT_W-1:0] fib_out_q, fib_out_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  // Captured input, kept only so the result can be cross-checked at completion.
  logic [IN_W-1:0]  bin_q, bin_d;

  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    fib_out_d = fib_out_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    bin_d     = bin_q;

    unique case (state_q)
      IDLE: begin
        if (en_b_f) begin
          res_d    = FW'(bin_in);
          a_d      = FW'(1);
          b_d      = FW'(2);
          idx_d    = '0;
          shadow_d = '0;
          busy_d   = 1'b1;
          bin_d    = bin_in;
          state_d  = GROW;
        end
      end

      GROW: begin
        // a always holds the weight of bit idx, b the weight of bit idx+1.
        if ((b_q <= res_q) && (idx_q < IDX_MAX)) begin
          a_d   = b_q;
          b_d   = a_q + b_q;
          idx_d = idx_q + IDX_W'(1);
        end else begin
          state_d = DESCEND;
        end
      end

      DESCEND: begin
        if (a_q <= res_q) begin
          shadow_d[idx_q] = 1'b1;
          res_d           = res_q - a_q;
        end
        a_d   = b_q - a_q;
        b_d   = a_q;
        idx_d = idx_q - IDX_W'(1);
        if (idx_q == '0) begin
          fib_out_d = shadow_d;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      res_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      fib_out_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      bin_q     <= '0;
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      fib_out_q <= fib_out_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      bin_q     <= bin_d;
    end
  end

  assign fib_out      = fib_out_q;
  assign convert_done = done_q;
  assign busy         = busy_q;

  // An undersized OUT_W silently truncates the code word; flag it here.
  a_capacity : assert property (@(posedge clk) disable iff (!rst)
    (state_q == GROW && b_q <= res_q) |-> (idx_q < IDX_MAX));

  a_no_adjacent : assert property (@(posedge clk) disable iff (!rst)
    convert_done |-> ((fib_out & (fib_out >> 1)) == '0));

  if (IN_W == IN_W_DEF && OUT_W == OUT_W_DEF) begin : g_ref_chk
    a_matches_ref : assert property (@(posedge clk) disable iff (!rst)
      convert_done |-> (fib_out == zeck_ref(bin_q)));
  end

endmodule

// File: tb/tb_bin_to_fibonacci.sv
module tb_bin_to_fibonacci;
  import fib_pkg::*;

  typedef struct {
    logic [31:0] code;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en_b_f;
  logic [15:0] bin_in;
  logic [31:0] fib_out;
  logic        convert_done;
  logic        busy;

  int   total;
  int   bad;
  int   cyc;
  int   busy_cnt;
  int   last_done;
  exp_t sb[$];

  bin_to_fibonacci #(
    .IN_W (16),
    .OUT_W(32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en_b_f      (en_b_f),
    .bin_in      (bin_in),
    .fib_out     (fib_out),
    .convert_done(convert_done),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Latency follows from the highest set code bit: 2*top + 2.
  function automatic int ref_lat(input logic [31:0] code);
    int top;
    top = 0;
    for (int k = 0; k < 32; k++) begin
      if (code[k]) top = k;
    end
    return 2 * top + 2;
  endfunction

  task automatic push(input logic [31:0] code, input int lat);
    exp_t e;
    e.code = code;
    e.lat  = lat;
    e.acc  = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", 64'(n < 200), 64'd1);
  endtask

  task automatic issue(input logic [15:0] v, input logic [31:0] code, input int lat);
    wait_idle();
    @(negedge clk);
    bin_in = v;
    en_b_f = 1'b1;
    @(posedge clk);
    #1;
    en_b_f = 1'b0;
    push(code, lat);
    chk("busy_start", 64'(busy), 64'd1);
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals completion.
  initial begin
    exp_t e;
    busy_cnt  = 0;
    last_done = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_cnt = 0;
      end else if (convert_done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done with fib_out 0x%0h expected no done", fib_out);
        end else begin
          e = sb.pop_front();
          chk("fib_out", 64'(fib_out), 64'(e.code));
          chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          chk("busy_cycles", 64'(busy_cnt), 64'(e.lat));
          chk("no_adjacent", 64'(fib_out & (fib_out >> 1)), 64'd0);
          chk("high_bits_zero", 64'(fib_out[31:23]), 64'd0);
          chk("busy_at_done", 64'(busy), 64'd0);
        end
        last_done = cyc;
        busy_cnt  = 0;
      end else if (busy) begin
        busy_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [15:0] SweepVals [12] = '{
    16'd2, 16'd3, 16'd6, 16'd12, 16'd33, 16'd100,
    16'd46367, 16'd46368, 16'd65534, 16'd987, 16'd1596, 16'd28657
  };

  initial begin
    logic [15:0] v;
    logic [31:0] code;
    int          n;
    total  = 0;
    bad    = 0;
    cyc    = 0;
    rst    = 1'b0;
    en_b_f = 1'b0;
    bin_in = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_fib_out", 64'(fib_out), 64'd0);
    chk("reset_done", 64'(convert_done), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors with hand-computed code words and latencies.
    issue(16'd20, 32'h0000_002A, 12);
    issue(16'd30, 32'h0000_0051, 14);
    issue(16'd4, 32'h0000_0005, 6);
    issue(16'd5, 32'h0000_0008, 8);
    issue(16'd0, 32'h0000_0000, 2);
    issue(16'd1, 32'h0000_0001, 2);
    issue(16'd65535, zeck_ref(16'd65535), 46);

    // Request during busy must be dropped, not queued.
    issue(16'd20, 32'h0000_002A, 12);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bin_in = 16'd99;
    en_b_f = 1'b1;
    @(negedge clk);
    en_b_f = 1'b0;
    wait_idle();
    repeat (20) @(posedge clk);
    #1;
    chk("held_fib_out", 64'(fib_out), 64'h2A);

    // Abort mid-conversion.
    issue(16'd20, 32'h0000_002A, 12);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    chk("abort_fib_out", 64'(fib_out), 64'd0);
    chk("abort_done", 64'(convert_done), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("post_abort_idle", 64'(busy), 64'd0);
    issue(16'd7, 32'h0000_000A, 8);
    wait_idle();

    // Back-to-back with en_b_f held high: accept on the edge right after each done.
    for (int i = 0; i < 32; i++) begin
      v    = (i < 12) ? SweepVals[i] : 16'($urandom_range(0, 65535));
      code = zeck_ref(v);
      if (i == 0) begin
        @(negedge clk);
        bin_in = v;
        en_b_f = 1'b1;
      end else begin
        n = 0;
        while (busy && n < 100) begin
          @(posedge clk);
          #1;
          n++;
        end
        chk("stream_timeout", 64'(n < 100), 64'd1);
        bin_in = v;
      end
      @(posedge clk);
      #1;
      push(code, ref_lat(code));
      chk("stream_busy_start", 64'(busy), 64'd1);
      if (i > 0) chk("stream_gap", 64'(cyc - last_done), 64'd1);
      if (i == 31) en_b_f = 1'b0;
    end
    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
